// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: slot states, inactive
// output levels, digit code width and a width helper.
package seg7_pkg;

  localparam int CODE_W = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  localparam logic DP_OFF = 1'b1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot sequencer: alternates DRIVE and BLANK per digit and flags frame boundaries.
// Outputs are look-ahead: idx/drive/boundary describe the slot entered at the next edge.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int IDX_W        = clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             drive,
  output logic             boundary
);

  localparam int MAX_CYC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = clog2(MAX_CYC);

  slot_state_e      state, state_next;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             first, first_next;

  // The blank slot after reset or re-enable leads into digit 0 without advancing
  // the index and without counting as a frame boundary.
  always_comb begin
    state_next = state;
    idx        = idx_q;
    cnt_next   = cnt + CNT_W'(1);
    first_next = first;
    boundary   = 1'b0;
    if (!en) begin
      state_next = ST_BLANK;
      idx        = '0;
      cnt_next   = '0;
      first_next = 1'b1;
    end else begin
      case (state)
        ST_DRIVE: begin
          if (cnt == CNT_W'(DRIVE_CYCLES - 1)) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
          end
        end
        default: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_next = ST_DRIVE;
            cnt_next   = '0;
            if (first) begin
              idx        = '0;
              first_next = 1'b0;
            end else if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx      = '0;
              boundary = 1'b1;
            end else begin
              idx = idx_q + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign drive = (state_next == ST_DRIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      idx_q <= '0;
      cnt   <= '0;
      first <= 1'b1;
    end else begin
      state <= state_next;
      idx_q <= idx;
      cnt   <= cnt_next;
      first <= first_next;
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed scan controller for a common-anode display with tear-free updates.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         load,
  input  logic [CODE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  output logic [CODE_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]        an_n,
  output logic                         dp_n,
  output logic                         frame_tick,
  output logic                         pending
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic [IDX_W-1:0] idx;
  logic             drive;
  logic             boundary;

  seg7_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DRIVE_CYCLES(DRIVE_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .idx     (idx),
    .drive   (drive),
    .boundary(boundary)
  );

  logic [NUM_DIGITS-1:0][CODE_W-1:0] staging, staging_next, shadow, shadow_next;
  logic [NUM_DIGITS-1:0]             staging_dp, staging_dp_next, shadow_dp, shadow_dp_next;
  logic                              pending_next;
  logic                              lz_dark;

  // Shadow only changes at a frame boundary or while the display is disabled;
  // a load landing on that edge bypasses staging entirely.
  always_comb begin
    staging_next    = staging;
    staging_dp_next = staging_dp;
    shadow_next     = shadow;
    shadow_dp_next  = shadow_dp;
    pending_next    = pending;
    if (boundary || !en) begin
      if (load) begin
        shadow_next    = value;
        shadow_dp_next = dp_in;
      end else if (pending) begin
        shadow_next    = staging;
        shadow_dp_next = staging_dp;
      end
      pending_next = 1'b0;
    end else if (load) begin
      staging_next    = value;
      staging_dp_next = dp_in;
      pending_next    = 1'b1;
    end
  end

  always_comb begin
    lz_dark = 1'b0;
`ifdef LZ_BLANK_EN
    lz_dark = (idx != '0) && !shadow_dp_next[idx];
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && shadow_next[j] != '0) lz_dark = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging    <= '0;
      staging_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an_n       <= ALL_OFF;
      dp_n       <= DP_OFF;
      digit_code <= '0;
    end else begin
      staging    <= staging_next;
      staging_dp <= staging_dp_next;
      shadow     <= shadow_next;
      shadow_dp  <= shadow_dp_next;
      pending    <= pending_next;
      frame_tick <= boundary;
      if (drive) begin
        an_n       <= lz_dark ? ALL_OFF : ~(NUM_DIGITS'(1) << idx);
        dp_n       <= ~shadow_dp_next[idx];
        digit_code <= shadow_next[idx];
      end else begin
        an_n <= ALL_OFF;
        dp_n <= DP_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller (4 digits, 4 drive / 2 blank clocks),
// using a time-position reference model of the scan schedule.
module tb_seg7_scan_controller;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int B     = 2;
  localparam int FRAME = N * (D + B);

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_code;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;
  logic        pending;

  seg7_scan_controller #(
    .NUM_DIGITS  (N),
    .DRIVE_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .digit_code(digit_code),
    .an_n      (an_n),
    .dp_n      (dp_n),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cycle = 0;

  // Model: p counts clocks since the display (re)started; slots follow from it.
  int          p;
  logic [15:0] shadow_m, staged_m;
  logic [3:0]  shadow_dp_m, staged_dp_m;
  logic        pending_m;
  logic [3:0]  last_code;
  logic        m_drive;
  int          m_slot;
  logic [3:0]  exp_an, exp_code;
  logic        exp_dp, exp_tick;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic resetModel();
    p = 0;
    shadow_m = '0; staged_m = '0;
    shadow_dp_m = '0; staged_dp_m = '0;
    pending_m = 1'b0;
    last_code = '0;
  endtask

  task automatic checkReset();
    checkOutput("rst_an_n", 32'(an_n), 32'hF);
    checkOutput("rst_dp_n", 32'(dp_n), 32'h1);
    checkOutput("rst_digit_code", 32'(digit_code), 32'h0);
    checkOutput("rst_frame_tick", 32'(frame_tick), 32'h0);
    checkOutput("rst_pending", 32'(pending), 32'h0);
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic [15:0] v, input logic [3:0] d);
    logic bnd;
    logic dark;
    en = e; load = l; value = v; dp_in = d;
    @(posedge clk);
    cycle++;
    bnd = 1'b0;
    if (!e) p = 0;
    else begin
      p = p + 1;
      bnd = (p > B) && ((p - B) % FRAME == 0);
    end
    if (!e || bnd) begin
      if (l) begin shadow_m = v; shadow_dp_m = d; end
      else if (pending_m) begin shadow_m = staged_m; shadow_dp_m = staged_dp_m; end
      pending_m = 1'b0;
    end else if (l) begin
      staged_m = v; staged_dp_m = d; pending_m = 1'b1;
    end
    exp_tick = bnd;
    m_drive = 1'b0;
    m_slot = 0;
    if (p >= B) begin
      m_slot  = ((p - B) % FRAME) / (D + B);
      m_drive = (((p - B) % FRAME) % (D + B)) < D;
    end
    if (m_drive) begin
      dark = 1'b0;
`ifdef LZ_BLANK_EN
      dark = (m_slot != 0) && !shadow_dp_m[m_slot] && ((shadow_m >> (4 * m_slot)) == 16'h0);
`endif
      exp_an    = dark ? 4'hF : ~(4'b0001 << m_slot);
      exp_dp    = ~shadow_dp_m[m_slot];
      exp_code  = shadow_m[4*m_slot +: 4];
      last_code = exp_code;
    end else begin
      exp_an   = 4'hF;
      exp_dp   = 1'b1;
      exp_code = last_code;
    end
    #1;
    checkOutput("an_n", 32'(an_n), 32'(exp_an));
    checkOutput("dp_n", 32'(dp_n), 32'(exp_dp));
    checkOutput("digit_code", 32'(digit_code), 32'(exp_code));
    checkOutput("frame_tick", 32'(frame_tick), 32'(exp_tick));
    checkOutput("pending", 32'(pending), 32'(pending_m));
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    logic [3:0] exp1 [8];
    logic       found;
    int         dp_hits, dp_low;
    exp1 = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    resetModel();

    // 1: start-up blank, first digit, then regular frames
    en = 1'b1; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
      checkOutput("s1_an_seq", 32'(an_n), 32'(exp1[i]));
    end
    idle(2 * FRAME);

    // 2: mid-frame load held until boundary; dp only on digit 2
    idle(5);
    applyStimulus(1'b1, 1'b1, 16'h1234, 4'b0100);
    checkOutput("s2_pending", 32'(pending), 32'h1);
    found = 1'b0;
    for (int i = 0; i < FRAME + 2 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
      found = frame_tick;
    end
    checkOutput("s2_tick_seen", 32'(found), 32'h1);
    checkOutput("s2_pending_clr", 32'(pending), 32'h0);
    dp_hits = 0; dp_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (dp_n == 1'b0) dp_low++;
      if (dp_n == 1'b0 && an_n == 4'b1011) dp_hits++;
      if (i < FRAME - 1) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    end
    checkOutput("s2_dp_low", 32'(dp_low), D);
    checkOutput("s2_dp_digit2", 32'(dp_hits), D);

    // 3: back-to-back loads, last wins
    idle(3);
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'h0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'h0);
    idle(2 * FRAME);

    // 4: load on the boundary edge goes straight to the display
    found = 1'b0;
    for (int i = 0; i < FRAME + 2 && !found; i++) begin
      if ((p + 1 > B) && ((p + 1 - B) % FRAME == 0)) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    end
    checkOutput("s4_found", 32'(found), 32'h1);
    applyStimulus(1'b1, 1'b1, 16'h0909, 4'h0);
    checkOutput("s4_tick", 32'(frame_tick), 32'h1);
    checkOutput("s4_pending", 32'(pending), 32'h0);
    idle(FRAME);

    // 5: disable while digit 2 is driven, then re-enable
    found = 1'b0;
    for (int i = 0; i < FRAME + 2 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
      found = m_drive && (m_slot == 2);
    end
    checkOutput("s5_found", 32'(found), 32'h1);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
    checkOutput("s5_an_off", 32'(an_n), 32'hF);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    checkOutput("s5_reblank", 32'(an_n), 32'hF);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    checkOutput("s5_digit0", 32'(an_n), 32'hE);

    // 6: leading zeros (blanked only when LZ_BLANK_EN is defined)
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'h0);
    idle(2 * FRAME + 4);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
                    16'($urandom), 4'($urandom));
      if (i == 200) begin
        #2 rst = 1'b1;
        #1;
        checkReset();
        resetModel();
        @(posedge clk);
        #1 rst = 1'b0;
        checkReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
